bypass_network: RTL and testbench
=================================

# bypass_network

Parametrised operand bypass network for the pipelined datapath, successor to the two-operand forwarding unit. It serves NREAD register read ports at the ID/EX boundary. Each port takes its operand from the EX/MEM result, the MEM/WB result, a HIST-deep buffer of recently retired writebacks, or the register file, in that priority. It also detects load-use hazards and holds a stall request through a small wait FSM until data memory returns the load. It keeps a saturating stall-cycle counter and a sticky timeout flag for debug.

## Interface
- DATA_W, 32, operand/result width
- REG_W, 5, register index width
- NREAD, 2, number of read ports (packed buses, port 0 in LSBs)
- HIST, 2, retired-writeback buffer depth (≥1)
- TIMEOUT, 255, WAIT cycles before timeout flag sets

- CLK  in  1  clock, all state on rising edge
- nRST  in  1  reset; synchronous, active-low
- en  in  1  pipeline advance; history buffer shifts only when 1
- ex_wen  in  1  EX/MEM instruction writes a register
- ex_isload  in  1  EX/MEM instruction is a load
- ex_rd  in  REG_W  EX/MEM destination
- ex_data  in  DATA_W  EX/MEM result (load data when dhit=1)
- dhit  in  1  load data valid on ex_data this cycle
- mem_wen  in  1  MEM/WB writes a register
- mem_rd  in  REG_W  MEM/WB destination
- mem_data  in  DATA_W  MEM/WB writeback value
- src_rs  in  NREAD*REG_W  source register per port
- src_rfdata  in  NREAD*DATA_W  register-file read data per port
- opnd  out  NREAD*DATA_W  selected operand per port
- fwd_sel  out  NREAD*2  per port: 0 regfile, 1 EX/MEM, 2 MEM/WB, 3 history
- stall  out  1  load-use stall request
- stall_cnt  out  32  saturating count of stall cycles
- timeout  out  1  sticky: a WAIT lasted TIMEOUT cycles

## Operation
- Match per port p, per source s: s write-enable, s_rd == src_rs[p], src_rs[p] != 0. Register 0 never forwards, so opnd = src_rfdata and fwd_sel = 0.
- Priority per port: EX/MEM > MEM/WB > hist[0] (newest) … hist[HIST-1] (oldest) > regfile.
- History entry: {valid, rd, data}. When en=1: hist[0] <= {mem_wen && mem_rd!=0, mem_rd, mem_data}, and hist[i] <= hist[i-1]. When en=0 all entries hold.
- Load hazard: some port matches EX/MEM with ex_isload=1 and dhit=0. EX/MEM data is then not forwardable. stall=1 and that port's opnd/fwd_sel are don't-care.
- EX/MEM load match with dhit=1: forward ex_data (fwd_sel=1) and do not stall.
- FSM states RUN and WAIT:
  - RUN -> WAIT when load hazard.
  - WAIT -> RUN when dhit=1 or the hazard clears (e.g. ex_wen drops).
  - WAIT otherwise stays.
- stall = load hazard, combinational, in either state. The state only drives wait_cnt.
- wait_cnt, internal 8+ bits:
  - Cleared in RUN.
  - Increments each WAIT cycle.
  - When it reaches TIMEOUT, timeout <= 1 and stays set until reset.
- stall_cnt increments each cycle stall=1 and saturates at 0xFFFFFFFF.

## Timing
- Forwarding path is combinational, with zero-cycle latency from source inputs to opnd/fwd_sel.
- History and counters update on the rising CLK edge. A writeback presented with en=1 is visible in hist[0] the next cycle.
- Reset (nRST=0 at an edge), including mid-WAIT:
  - state=RUN, wait_cnt=0, stall_cnt=0, timeout=0, all hist valid=0.
  - stall is forced 0 while nRST=0.
  - opnd/fwd_sel still follow inputs with an empty history.
- Simultaneous matches on several sources: highest priority wins. Duplicate rd entries in history resolve to the newest.
- Same cycle as en=1: opnd reflects pre-shift history.
- No stall is issued for MEM/WB or history matches.

## Test plan
- Forwarding priority:
  - Stimulus: port0 rs=5; ex_wen=1 ex_rd=5 ex_data=0xAAAA; mem_wen=1 mem_rd=5 mem_data=0xBBBB.
  - Response: opnd0=0xAAAA, fwd_sel0=1. Drop ex_wen and the response becomes 0xBBBB, sel=2.
- History:
  - Stimulus: mem_wen=1 rd=7 data=0x1234 with en=1 for one cycle, then mem_wen=0, then port1 rs=7 src_rfdata=0.
  - Response: opnd1=0x1234, sel=3.
  - Then HIST further en=1 cycles with no writes: entry ages out and opnd1=0, sel=0.
  - en=0 instead holds the entry indefinitely.
- Register 0:
  - Stimulus: ex_wen=1 ex_rd=0 ex_data=0xFFFF, rs=0, src_rfdata=0.
  - Response: opnd=0, sel=0, stall=0.
- Load-use:
  - Stimulus: ex_isload=1 ex_rd=3 rs=3, dhit=0 for 4 cycles, then dhit=1 ex_data=0xCAFE.
  - Response: stall=1 for 4 cycles and stall_cnt=4; on the dhit cycle stall=0, opnd=0xCAFE, sel=1, and state returns to RUN.
- Timeout and reset:
  - Stimulus: hold the load hazard with dhit=0 for TIMEOUT cycles.
  - Response: timeout=1 and stays 1 after the hazard clears.
  - Then assert nRST=0 mid-WAIT: next edge gives stall_cnt=0, timeout=0, state RUN, stall=0.
- Saturation: preload stall_cnt near max (force), stall 3 cycles, and stall_cnt holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/bypass_network.sv
// Operand bypass network: per-port forwarding from EX/MEM, MEM/WB, a retired
// writeback history and the register file, plus load-use stall tracking.
module bypass_network #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int NREAD   = 2,
    parameter int HIST    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    en,
    input  logic                    ex_wen,
    input  logic                    ex_isload,
    input  logic [REG_W-1:0]        ex_rd,
    input  logic [DATA_W-1:0]       ex_data,
    input  logic                    dhit,
    input  logic                    mem_wen,
    input  logic [REG_W-1:0]        mem_rd,
    input  logic [DATA_W-1:0]       mem_data,
    input  logic [NREAD*REG_W-1:0]  src_rs,
    input  logic [NREAD*DATA_W-1:0] src_rfdata,
    output logic [NREAD*DATA_W-1:0] opnd,
    output logic [NREAD*2-1:0]      fwd_sel,
    output logic                    stall,
    output logic [31:0]             stall_cnt,
    output logic                    timeout
);

    localparam int WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    logic              hist_vld_r  [HIST];
    logic [REG_W-1:0]  hist_rd_r   [HIST];
    logic [DATA_W-1:0] hist_data_r [HIST];

    logic                    state_r;
    logic                    state_nx_s;
    logic                    waiting_s;
    logic [WAIT_W-1:0]       wait_cnt_r;
    logic [31:0]             stall_cnt_r;
    logic                    timeout_r;
    logic                    hazard_s;
    logic                    stall_s;
    logic [NREAD*DATA_W-1:0] opnd_s;
    logic [NREAD*2-1:0]      fwd_sel_s;

    // Retired-writeback history: shift in the MEM/WB writeback when the pipe advances
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < HIST; i++) begin
                hist_vld_r[i] <= 1'b0;
            end
        end else if (en) begin
            hist_vld_r[0]  <= mem_wen && (mem_rd != '0);
            hist_rd_r[0]   <= mem_rd;
            hist_data_r[0] <= mem_data;
            for (int i = 1; i < HIST; i++) begin
                hist_vld_r[i]  <= hist_vld_r[i-1];
                hist_rd_r[i]   <= hist_rd_r[i-1];
                hist_data_r[i] <= hist_data_r[i-1];
            end
        end
    end

    // Per-port source selection and load-use hazard detection
    always_comb begin : fwd_mux
        logic [REG_W-1:0]  rs_v;
        logic [DATA_W-1:0] data_v;
        logic [1:0]        sel_v;
        hazard_s  = 1'b0;
        opnd_s    = '0;
        fwd_sel_s = '0;
        rs_v      = '0;
        data_v    = '0;
        sel_v     = 2'd0;
        for (int p = 0; p < NREAD; p++) begin
            rs_v   = src_rs[p*REG_W +: REG_W];
            data_v = src_rfdata[p*DATA_W +: DATA_W];
            sel_v  = 2'd0;
            if (rs_v == '0) begin
                sel_v = 2'd0;
            end else if (ex_wen && (ex_rd == rs_v)) begin
                sel_v  = 2'd1;
                data_v = ex_data;
                if (ex_isload && !dhit) begin
                    hazard_s = 1'b1;
                end else begin
                    hazard_s = hazard_s;
                end
            end else if (mem_wen && (mem_rd == rs_v)) begin
                sel_v  = 2'd2;
                data_v = mem_data;
            end else begin
                // Scan oldest to newest so the newest duplicate wins
                for (int h = HIST - 1; h >= 0; h--) begin
                    if (nRST && hist_vld_r[h] && (hist_rd_r[h] == rs_v)) begin
                        sel_v  = 2'd3;
                        data_v = hist_data_r[h];
                    end else begin
                        sel_v = sel_v;
                    end
                end
            end
            opnd_s[p*DATA_W +: DATA_W] = data_v;
            fwd_sel_s[p*2 +: 2]        = sel_v;
        end
    end

    // Stall request is masked while reset is held
    always_comb begin
        stall_s = nRST && hazard_s;
    end

    // Wait FSM state register
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Wait FSM next state: stay in WAIT exactly while the hazard persists
    always_comb begin
        state_nx_s = ST_RUN;
        case (state_r)
            ST_RUN:  state_nx_s = hazard_s ? ST_WAIT : ST_RUN;
            ST_WAIT: state_nx_s = hazard_s ? ST_WAIT : ST_RUN;
            default: state_nx_s = ST_RUN;
        endcase
    end

    // Wait FSM output decode
    always_comb begin
        waiting_s = 1'b0;
        case (state_r)
            ST_WAIT: waiting_s = 1'b1;
            ST_RUN:  waiting_s = 1'b0;
            default: waiting_s = 1'b0;
        endcase
    end

    // Wait-length counter, sticky timeout and saturating stall counter
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wait_cnt_r  <= '0;
            timeout_r   <= 1'b0;
            stall_cnt_r <= 32'd0;
        end else begin
            if (waiting_s) begin
                if (wait_cnt_r != WAIT_MAX) begin
                    wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                end
                if (wait_cnt_r == WAIT_LAST) begin
                    timeout_r <= 1'b1;
                end
            end else begin
                wait_cnt_r <= '0;
            end
            if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
        end
    end

    assign opnd      = opnd_s;
    assign fwd_sel   = fwd_sel_s;
    assign stall     = stall_s;
    assign stall_cnt = stall_cnt_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_bypass_network.sv
// Directed bench for bypass_network: a queue-based reference model checked every
// cycle, plus hand-computed literal expectations at the interesting points.
module tb_bypass_network;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int NREAD   = 2;
    localparam int HIST    = 2;
    localparam int TIMEOUT = 255;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic nRST, en, ex_wen, ex_isload, dhit, mem_wen;
    logic [REG_W-1:0]  ex_rd, mem_rd;
    logic [DATA_W-1:0] ex_data, mem_data;
    logic [REG_W-1:0]  rs [NREAD];
    logic [DATA_W-1:0] rf [NREAD];
    logic [NREAD*REG_W-1:0]  src_rs;
    logic [NREAD*DATA_W-1:0] src_rfdata;
    logic [NREAD*DATA_W-1:0] opnd;
    logic [NREAD*2-1:0]      fwd_sel;
    logic        stall, timeout;
    logic [31:0] stall_cnt;

    always_comb begin
        src_rs     = '0;
        src_rfdata = '0;
        for (int p = 0; p < NREAD; p++) begin
            src_rs[p*REG_W +: REG_W]       = rs[p];
            src_rfdata[p*DATA_W +: DATA_W] = rf[p];
        end
    end

    bypass_network #(.DATA_W(DATA_W), .REG_W(REG_W), .NREAD(NREAD), .HIST(HIST), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST), .en(en), .ex_wen(ex_wen), .ex_isload(ex_isload),
        .ex_rd(ex_rd), .ex_data(ex_data), .dhit(dhit), .mem_wen(mem_wen),
        .mem_rd(mem_rd), .mem_data(mem_data), .src_rs(src_rs), .src_rfdata(src_rfdata),
        .opnd(opnd), .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt), .timeout(timeout)
    );

    typedef struct {
        logic              v;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] d;
    } wb_t;

    wb_t         retired [$];
    logic [31:0] m_cnt = 32'd0;
    logic        m_timeout = 1'b0;
    logic        m_wait = 1'b0;
    int          m_wcyc = 0;
    int          n_vec = 0;
    int          n_mis = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] o_d(input int p);
        return {32'd0, opnd[p*DATA_W +: DATA_W]};
    endfunction

    function automatic logic [63:0] o_s(input int p);
        return {62'd0, fwd_sel[p*2 +: 2]};
    endfunction

    function automatic logic m_port_hazard(input int p);
        return (rs[p] != 5'd0) && ex_wen && (ex_rd == rs[p]) && ex_isload && !dhit;
    endfunction

    function automatic logic m_hazard();
        logic h = 1'b0;
        for (int p = 0; p < NREAD; p++) h = h | m_port_hazard(p);
        return h;
    endfunction

    // Expected operand for a port: first matching source in priority order
    function automatic void m_port(input int p, output logic [DATA_W-1:0] d, output logic [1:0] s);
        d = rf[p];
        s = 2'd0;
        if (rs[p] == 5'd0) return;
        if (ex_wen && ex_rd == rs[p]) begin d = ex_data; s = 2'd1; return; end
        if (mem_wen && mem_rd == rs[p]) begin d = mem_data; s = 2'd2; return; end
        if (!nRST) return;
        foreach (retired[i]) begin
            if (retired[i].v && retired[i].rd == rs[p]) begin
                d = retired[i].d;
                s = 2'd3;
                return;
            end
        end
    endfunction

    // Model update on each rising edge
    initial forever begin
        @(posedge CLK);
        if (!nRST) begin
            retired.delete();
            m_cnt = 32'd0; m_timeout = 1'b0; m_wait = 1'b0; m_wcyc = 0;
        end else begin
            if (m_hazard() && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (m_wait) begin
                if (m_wcyc < TIMEOUT) m_wcyc++;
                if (m_wcyc == TIMEOUT) m_timeout = 1'b1;
            end else begin
                m_wcyc = 0;
            end
            m_wait = m_hazard();
            if (en) begin
                retired.push_front('{v: mem_wen && (mem_rd != 5'd0), rd: mem_rd, d: mem_data});
                if (retired.size() > HIST) void'(retired.pop_back());
            end
        end
    end

    // Per-cycle comparison on the falling edge
    initial forever begin
        logic [DATA_W-1:0] d;
        logic [1:0]        s;
        @(negedge CLK);
        for (int p = 0; p < NREAD; p++) begin
            if (!(nRST && m_port_hazard(p))) begin
                m_port(p, d, s);
                chk($sformatf("opnd%0d", p), o_d(p), {32'd0, d});
                chk($sformatf("fwd_sel%0d", p), o_s(p), {62'd0, s});
            end
        end
        chk("stall", 64'(stall), 64'(nRST && m_hazard()));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        chk("timeout", 64'(timeout), 64'(m_timeout));
        chk("state", 64'(dut.state_r), 64'(m_wait));
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0; en = 1'b0; ex_wen = 1'b0; ex_isload = 1'b0; dhit = 1'b0;
        mem_wen = 1'b0; ex_rd = 5'd0; mem_rd = 5'd0; ex_data = 32'd0; mem_data = 32'd0;
        for (int p = 0; p < NREAD; p++) begin rs[p] = 5'd0; rf[p] = 32'd0; end
        cyc(); cyc();
        nRST = 1'b1;
        #3;
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);

        // Priority: EX/MEM over MEM/WB, then MEM/WB alone
        cyc();
        rs[0] = 5'd5; rf[0] = 32'h0000_1111;
        ex_wen = 1'b1; ex_rd = 5'd5; ex_data = 32'h0000_AAAA;
        mem_wen = 1'b1; mem_rd = 5'd5; mem_data = 32'h0000_BBBB;
        #3;
        chk("prio_ex_d", o_d(0), 64'h0000_AAAA);
        chk("prio_ex_s", o_s(0), 64'd1);
        cyc();
        ex_wen = 1'b0;
        #3;
        chk("prio_mem_d", o_d(0), 64'h0000_BBBB);
        chk("prio_mem_s", o_s(0), 64'd2);

        // History: capture, hold with en=0, then age out
        cyc();
        rs[0] = 5'd0; en = 1'b1; mem_wen = 1'b1; mem_rd = 5'd7; mem_data = 32'h0000_1234;
        cyc();
        en = 1'b0; mem_wen = 1'b0; rs[1] = 5'd7; rf[1] = 32'd0;
        #3;
        chk("hist_d", o_d(1), 64'h0000_1234);
        chk("hist_s", o_s(1), 64'd3);
        cyc(); cyc(); cyc();
        #3;
        chk("hist_hold_s", o_s(1), 64'd3);
        cyc();
        en = 1'b1;
        cyc();
        #3;
        chk("hist_age1_s", o_s(1), 64'd3);
        cyc();
        #3;
        chk("hist_gone_d", o_d(1), 64'd0);
        chk("hist_gone_s", o_s(1), 64'd0);

        // Duplicate destinations in history: newest wins
        cyc();
        mem_wen = 1'b1; mem_rd = 5'd9; mem_data = 32'd1;
        cyc();
        mem_data = 32'd2;
        cyc();
        en = 1'b0; mem_wen = 1'b0; rs[1] = 5'd9; rf[1] = 32'h0000_00EE;
        #3;
        chk("hist_dup_d", o_d(1), 64'd2);

        // Register 0 never forwards nor stalls
        cyc();
        rs[1] = 5'd0; rf[1] = 32'd0; rs[0] = 5'd0; rf[0] = 32'd0;
        ex_wen = 1'b1; ex_rd = 5'd0; ex_data = 32'h0000_FFFF; ex_isload = 1'b1; dhit = 1'b0;
        #3;
        chk("r0_d", o_d(0), 64'd0);
        chk("r0_s", o_s(0), 64'd0);
        chk("r0_stall", 64'(stall), 64'd0);

        // Load-use: four stall cycles, then data returns
        cyc();
        ex_rd = 5'd3; ex_data = 32'd0; rs[0] = 5'd3;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk("lu_stall", 64'(stall), 64'd1);
            cyc();
        end
        dhit = 1'b1; ex_data = 32'h0000_CAFE;
        #3;
        chk("lu_cnt", 64'(stall_cnt), 64'd4);
        chk("lu_nostall", 64'(stall), 64'd0);
        chk("lu_d", o_d(0), 64'h0000_CAFE);
        chk("lu_s", o_s(0), 64'd1);
        cyc();
        ex_wen = 1'b0; ex_isload = 1'b0; dhit = 1'b0;
        #3;
        chk("lu_run", 64'(dut.state_r), 64'd0);
        cyc();

        // Timeout: hold the hazard until TIMEOUT WAIT cycles elapse
        ex_wen = 1'b1; ex_isload = 1'b1; ex_rd = 5'd3; rs[0] = 5'd3;
        repeat (TIMEOUT) cyc();
        #3;
        chk("to_early", 64'(timeout), 64'd0);
        cyc();
        #3;
        chk("to_set", 64'(timeout), 64'd1);
        cyc();
        ex_wen = 1'b0;
        cyc(); cyc();
        #3;
        chk("to_sticky", 64'(timeout), 64'd1);

        // Reset while waiting
        ex_wen = 1'b1;
        cyc(); cyc();
        nRST = 1'b0;
        #3;
        chk("rst_stall_mask", 64'(stall), 64'd0);
        cyc();
        #3;
        chk("rst_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_to", 64'(timeout), 64'd0);
        chk("rst_state", 64'(dut.state_r), 64'd0);
        nRST = 1'b1; ex_wen = 1'b0;
        cyc();

        // Saturation from a preloaded counter
        force dut.stall_cnt_r = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_r;
        cyc();
        ex_wen = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #3;
            chk("sat_cnt", 64'(stall_cnt), 64'hFFFF_FFFF);
        end
        cyc();
        ex_wen = 1'b0; ex_isload = 1'b0;
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
